peak_window_scheduler: RTL and testbench

Time-multiplexed peak detector and window scheduler for the hydrophone acquisition path. Takes the interleaved per-channel SPI ADC sample stream, tracks the maximum sample of each channel over a fixed window of sample frames, then snapshots all channel peaks and hands them out one channel at a time over a valid/ack handshake. Sits between the SPI ADC front end and the ping-detection/threshold logic. Replaces per-channel max registers cleared by a bit-count strobe with one scheduled, shared comparator.

---
 rtl/acoustics_pkg.sv | 18 +
 rtl/peak_bank.sv | 39 +++
 rtl/peak_window_scheduler.sv | 141 ++++++++++++++
 tb/tb_peak_window_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acoustics_pkg.sv
// Shared types and default sizes for the hydrophone acquisition path.
package acoustics_pkg;

    localparam int DATA_W = 10;
    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic {
        IDLE,
        RUN
    } run_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_VALID
    } out_state_t;

endpackage

// File: rtl/peak_bank.sv
// Per-channel running maxima with one shared compare-update port.
// snap is the bank contents with this cycle's update already folded in.
module peak_bank
    import acoustics_pkg::*;
#(
    parameter int NUM_CH = acoustics_pkg::NUM_CH,
    parameter int DATA_W = acoustics_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           upd,
    input  logic [$clog2(NUM_CH)-1:0]      upd_ch,
    input  logic [DATA_W-1:0]              upd_data,
    input  logic                           clear,
    output logic [NUM_CH-1:0][DATA_W-1:0]  snap
);

    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0][DATA_W-1:0] peak_q;

    always_comb begin
        snap = peak_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (upd && upd_ch == CW'(i) && upd_data > peak_q[i]) begin
                snap[i] = upd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            peak_q <= '0;
        end else begin
            peak_q <= snap;
        end
    end

endmodule

// File: rtl/peak_window_scheduler.sv
// Windowed per-channel peak detector; snapshots all peaks at window end
// and drains them one channel at a time over a valid/ack handshake.
module peak_window_scheduler
    import acoustics_pkg::*;
#(
    parameter int NUM_CH     = acoustics_pkg::NUM_CH,
    parameter int DATA_W     = acoustics_pkg::DATA_W,
    parameter int WINDOW_LEN = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Enable,
    input  logic                      Sample_Valid,
    input  logic [$clog2(NUM_CH)-1:0] Sample_Channel,
    input  logic [DATA_W-1:0]         Sample_Data,
    output logic                      Peak_Valid,
    input  logic                      Peak_Ack,
    output logic [$clog2(NUM_CH)-1:0] Peak_Channel,
    output logic [DATA_W-1:0]         Peak_Value,
    output logic                      Window_Done,
    output logic                      Overrun
);

    localparam int CW = $clog2(NUM_CH);
    localparam int FW = $clog2(WINDOW_LEN);
    localparam logic [CW:0]   CH_LIM  = (CW+1)'(NUM_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic [FW-1:0] LAST_FR = FW'(WINDOW_LEN - 1);

    run_state_t run_q, run_d;
    out_state_t out_q, out_d;

    logic [FW-1:0]                 frame_q;
    logic [CW-1:0]                 idx_q, idx_d;
    logic [NUM_CH-1:0][DATA_W-1:0] shadow_q;
    logic [NUM_CH-1:0][DATA_W-1:0] snap;

    logic accept, last_ch, eow, stop, clr_live;
    logic xfer, last_xfer, load, drop;
    logic done_q, ovr_q;

    // Zero-extended compare keeps the range check meaningful for any NUM_CH
    assign accept    = run_q == RUN && Enable && Sample_Valid
                       && {1'b0, Sample_Channel} < CH_LIM;
    assign last_ch   = Sample_Channel == LAST_CH;
    assign eow       = accept && last_ch && frame_q == LAST_FR;
    assign stop      = run_q == RUN && !Enable;
    assign clr_live  = stop || eow;
    assign xfer      = out_q == OUT_VALID && Peak_Ack;
    assign last_xfer = xfer && idx_q == LAST_CH;
    assign load      = eow && (out_q == OUT_IDLE || last_xfer);
    assign drop      = eow && !load;

    peak_bank #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .upd      (accept),
        .upd_ch   (Sample_Channel),
        .upd_data (Sample_Data),
        .clear    (clr_live),
        .snap     (snap)
    );

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            frame_q <= '0;
        end else if (accept && last_ch) begin
            frame_q <= eow ? '0 : frame_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= IDLE;
            out_q    <= OUT_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            run_q  <= run_d;
            out_q  <= out_d;
            idx_q  <= idx_d;
            done_q <= last_xfer;
            ovr_q  <= drop;
            if (load) begin
                shadow_q <= snap;
            end
        end
    end

    always_comb begin
        run_d = run_q;
        unique case (run_q)
            IDLE:    if (Enable)  run_d = RUN;
            RUN:     if (!Enable) run_d = IDLE;
            default: run_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        idx_d = idx_q;
        unique case (out_q)
            OUT_IDLE: begin
                if (load) begin
                    out_d = OUT_VALID;
                    idx_d = '0;
                end
            end
            OUT_VALID: begin
                if (last_xfer) begin
                    out_d = load ? OUT_VALID : OUT_IDLE;
                    idx_d = '0;
                end else if (xfer) begin
                    idx_d = idx_q + CW'(1);
                end
            end
            default: begin
                out_d = OUT_IDLE;
                idx_d = '0;
            end
        endcase
    end

    always_comb begin
        Peak_Valid   = out_q == OUT_VALID;
        Peak_Channel = '0;
        Peak_Value   = '0;
        if (out_q == OUT_VALID) begin
            Peak_Channel = idx_q;
            Peak_Value   = shadow_q[idx_q];
        end
        Window_Done = done_q;
        Overrun     = ovr_q;
    end

endmodule

// File: tb/tb_peak_window_scheduler.sv
// Scoreboard bench for peak_window_scheduler: random and directed samples
// against a frame/window-level reference model.
module tb_peak_window_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 10;
    localparam int WL  = 4;
    localparam int CW  = $clog2(NCH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Enable = 1'b0;
    logic          Sample_Valid = 1'b0;
    logic [CW-1:0] Sample_Channel = '0;
    logic [DW-1:0] Sample_Data = '0;
    logic          Peak_Ack = 1'b0;
    logic          Peak_Valid;
    logic [CW-1:0] Peak_Channel;
    logic [DW-1:0] Peak_Value;
    logic          Window_Done;
    logic          Overrun;

    peak_window_scheduler #(
        .NUM_CH     (NCH),
        .DATA_W     (DW),
        .WINDOW_LEN (WL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Enable         (Enable),
        .Sample_Valid   (Sample_Valid),
        .Sample_Channel (Sample_Channel),
        .Sample_Data    (Sample_Data),
        .Peak_Valid     (Peak_Valid),
        .Peak_Ack       (Peak_Ack),
        .Peak_Channel   (Peak_Channel),
        .Peak_Value     (Peak_Value),
        .Window_Done    (Window_Done),
        .Overrun        (Overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        bit done;
        bit ovr;
        bit zchk;
    } exp_t;

    typedef struct {
        int ch;
        int val;
    } pk_t;

    exp_t exp_q[$];
    pk_t  xfer_q[$];
    pk_t  log_q[$];

    int vectors = 0;
    int miscompares = 0;
    int ovr_seen = 0;

    // Reference model state: window maxima, frame count, undrained peaks
    int pk[NCH];
    int cnt = 0;
    bit run = 0;
    int pending = 0;
    bit m_done = 0;
    bit m_ovr = 0;
    bit m_rst = 1;

    function automatic void chk(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_step(bit rst, bit en, bit v, int ch,
                                       int d, bit ack);
        bit xf, lst, acc, eow;
        if (rst) begin
            foreach (pk[c]) pk[c] = 0;
            cnt = 0;
            run = 0;
            pending = 0;
            m_done = 0;
            m_ovr = 0;
            m_rst = 1;
            xfer_q.delete();
            return;
        end
        m_rst = 0;
        xf  = pending > 0 && ack;
        lst = xf && pending == 1;
        acc = run && en && v && ch < NCH;
        eow = 0;
        if (run && !en) begin
            foreach (pk[c]) pk[c] = 0;
            cnt = 0;
        end
        m_done = lst;
        m_ovr = 0;
        if (acc) begin
            if (d > pk[ch]) pk[ch] = d;
            if (ch == NCH - 1) begin
                if (cnt == WL - 1) begin
                    eow = 1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
        if (xf) pending--;
        if (eow) begin
            if (pending > 0) begin
                m_ovr = 1;
            end else begin
                for (int c = 0; c < NCH; c++) xfer_q.push_back('{c, pk[c]});
                pending = NCH;
            end
            foreach (pk[c]) pk[c] = 0;
        end
        run = en;
    endfunction

    task automatic cycle(bit rst, bit en, bit v, int ch, int d, bit ack);
        @(posedge clk);
        #1;
        exp_q.push_back('{pending > 0, m_done, m_ovr, m_rst});
        reset = rst;
        Enable = en;
        Sample_Valid = v;
        Sample_Channel = CW'(ch);
        Sample_Data = DW'(d);
        Peak_Ack = ack;
        model_step(rst, en, v, ch, d, ack);
    endtask

    task automatic window(int base, bit ack);
        for (int f = 0; f < WL; f++)
            for (int c = 0; c < NCH; c++)
                cycle(0, 1, 1, c, base + c, ack);
    endtask

    task automatic idle(int n, bit en, bit ack);
        for (int i = 0; i < n; i++) cycle(0, en, 0, 0, 0, ack);
    endtask

    exp_t e;
    pk_t  p;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("peak_valid", Peak_Valid, e.valid);
            chk("window_done", Window_Done, e.done);
            chk("overrun", Overrun, e.ovr);
            if (e.zchk) begin
                chk("reset_channel", Peak_Channel, 0);
                chk("reset_value", Peak_Value, 0);
            end
        end
        if (Overrun) ovr_seen++;
        if (Peak_Valid && Peak_Ack) begin
            if (xfer_q.size() == 0) begin
                chk("unexpected_xfer", 1, 0);
            end else begin
                p = xfer_q.pop_front();
                chk("xfer_channel", Peak_Channel, p.ch);
                chk("xfer_value", Peak_Value, p.val);
            end
            log_q.push_back('{int'(Peak_Channel), int'(Peak_Value)});
        end
    end

    int vals[4] = '{3, 9, 5, 9};

    initial begin
        foreach (pk[c]) pk[c] = 0;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Round-robin {3,9,5,9}+c, ack held high
        log_q.delete();
        cycle(0, 1, 0, 0, 0, 1);
        for (int f = 0; f < WL; f++)
            for (int c = 0; c < NCH; c++)
                cycle(0, 1, 1, c, vals[f] + c, 1);
        idle(6, 1, 1);
        chk("rr_count", log_q.size(), NCH);
        for (int c = 0; c < NCH && c < log_q.size(); c++) begin
            chk("rr_channel", log_q[c].ch, c);
            chk("rr_value", log_q[c].val, 9 + c);
        end

        // Full-scale sample on ch2 in the last frame, then a quiet window
        log_q.delete();
        for (int f = 0; f < WL; f++)
            for (int c = 0; c < NCH; c++)
                cycle(0, 1, 1, c, (f == WL - 1 && c == 2) ? 10'h3FF : c + 1, 1);
        idle(6, 1, 1);
        chk("fullscale_count", log_q.size(), NCH);
        if (log_q.size() > 2) chk("fullscale_ch2", log_q[2].val, 1023);
        log_q.delete();
        window(7, 1);
        idle(6, 1, 1);
        if (log_q.size() > 2) chk("next_ch2", log_q[2].val, 9);
        else chk("next_count", log_q.size(), NCH);

        // Consumer stalled across two further windows
        log_q.delete();
        ovr_seen = 0;
        window(20, 0);
        window(50, 0);
        window(60, 0);
        idle(3, 1, 0);
        chk("overrun_pulses", ovr_seen, 2);
        idle(8, 1, 1);
        chk("stall_count", log_q.size(), NCH);
        for (int c = 0; c < NCH && c < log_q.size(); c++)
            chk("stall_value", log_q[c].val, 20 + c);

        // Enable dropped mid-window while a drain is pending
        log_q.delete();
        window(40, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, i % NCH, 100, 0);
        idle(3, 0, 1);
        idle(1, 1, 1);
        window(30, 1);
        idle(6, 1, 1);
        chk("enable_count", log_q.size(), 2 * NCH);
        for (int c = 0; c < NCH && log_q.size() >= 2 * NCH; c++) begin
            chk("enable_old", log_q[c].val, 40 + c);
            chk("enable_new", log_q[NCH + c].val, 30 + c);
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            cycle(0, $urandom_range(15) != 0, $urandom_range(3) != 0,
                  $urandom_range(NCH - 1), $urandom_range(1023),
                  $urandom_range(1));

        // Reset while a peak is being presented
        idle(3, 1, 1);
        idle(8, 0, 1);
        idle(1, 1, 0);
        window(5, 0);
        idle(2, 1, 0);
        chk("pre_reset_valid", Peak_Valid, 1);
        cycle(1, 1, 0, 0, 0, 0);
        idle(1, 1, 1);
        window(11, 1);
        idle(8, 0, 1);
        chk("xfer_left", xfer_q.size(), 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
